match_arbiter: RTL
==================

# match_arbiter

Round-robin arbiter that shares one phase-match tree between N_REQ row controllers. Each controller issues one beat (BEAT_SIZE phase1 samples plus positions). The arbiter forwards granted beats to the tree and routes each lane's returning disparity back to the controller that issued it. It sits between the per-row control blocks and the single match tree and supports up to MAX_OUTSTANDING beats in flight.

## Interface
- N_REQ, 4: number of requesting controllers (≥2).
- BEAT_SIZE, 8: samples per beat.
- DATA_WIDTH, 16: sample/disparity width.
- MAX_OUTSTANDING, 8: max beats issued but not yet returned on any lane; power of two.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  controller k has a beat.
- req_ready  out  N_REQ  beat of controller k accepted this cycle.
- req_phase  in  N_REQ×BEAT_SIZE×DATA_WIDTH  signed phase1 samples.
- req_pos  in  N_REQ×BEAT_SIZE×DATA_WIDTH  signed positions.
- abs_phase1  out  BEAT_SIZE×DATA_WIDTH  to match tree.
- abs_phase1_pos  out  BEAT_SIZE×DATA_WIDTH  to match tree.
- vld_o  out  1  one-cycle issue strobe to match tree.
- disparity  in  BEAT_SIZE×DATA_WIDTH  tree result per lane.
- vld_i  in  BEAT_SIZE  per-lane result strobe.
- rsp_disparity  out  BEAT_SIZE×DATA_WIDTH  registered result, broadcast to all controllers.
- rsp_vld  out  N_REQ×BEAT_SIZE  lane i of controller k valid.
- busy  out  1  any beat outstanding.
- err  out  1  sticky: vld_i seen on a lane with nothing outstanding.

## Operation
- Arbitration: round-robin, combinational. Search starts at rr_ptr. The lowest index ≥ rr_ptr (mod N_REQ) with req_valid set wins.
- req_ready[k] = grant[k] & ~stall. At most one bit is set.
- stall is asserted when any lane tag queue holds MAX_OUTSTANDING entries.
- On handshake (req_valid[k] & req_ready[k]):
  - Capture req_phase[k] and req_pos[k] into abs_phase1 and abs_phase1_pos.
  - Pulse vld_o next cycle.
  - Push tag k into all BEAT_SIZE lane tag queues.
  - rr_ptr becomes k+1 mod N_REQ. rr_ptr holds when there is no handshake.
- Results: lane i results return in issue order, but lanes are independent of each other.
  - When vld_i[i] is high with lane i queue non-empty: pop tag t, register disparity[i] into rsp_disparity[i], and set rsp_vld[t][i] next cycle for one cycle.
  - When vld_i[i] is high with lane i queue empty: set err. rsp_vld is not asserted. The queue is unchanged.
- Push and pop on the same lane in the same cycle are both performed; occupancy is unchanged. Full-with-pop still stalls that cycle, because stall uses current occupancy.
- busy = any lane queue non-empty.
- Abs outputs hold their value between issues. rsp_disparity[i] holds its value between strobes.
- Reset, including mid-operation:
  - rr_ptr=0, all queues empty, vld_o=0, rsp_vld=0, err=0, busy=0, abs_phase1/abs_phase1_pos/rsp_disparity=0.
  - In-flight tree results arriving after reset raise err. The system must also reset the tree.

## Timing
- req_ready depends combinationally on req_valid and on registered state. There is no combinational path from req_ready back to req_valid.
- Issue latency: handshake in cycle n → vld_o and tree inputs valid in cycle n+1.
- Return latency: vld_i[i] in cycle m → rsp_vld[t][i] and rsp_disparity[i] in cycle m+1.
- Throughput: one beat per cycle while not stalled. Back-to-back grants to different requesters are allowed.
- A requester holding req_valid is granted within N_REQ non-stalled cycles.
- Queue depth is exactly MAX_OUTSTANDING. Pointers are log2(MAX_OUTSTANDING) bits with an extra wrap bit. Count is log2(MAX_OUTSTANDING)+1 bits.

## Structure
- Package pmp_pkg holds:
  - tag_t, width $clog2(N_REQ).
  - beat_t, packed BEAT_SIZE×DATA_WIDTH.
  - function rr_pick(valid, ptr).
- Sub-module tag_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count). It is instantiated BEAT_SIZE times with first-word-fall-through dout.

## Test plan
- Single requester 0 sends one beat with phase=100..107 and pos=0..7. Tree returns all lanes 5 cycles later with disparity=3. Required: vld_o one cycle after handshake; rsp_vld[0]=8'hFF one cycle after vld_i; rsp_disparity=3; busy drops afterwards.
- All 4 requesters hold valid for 8 cycles, rr_ptr=0. Required: grant order 0,1,2,3,0,1,2,3; every tag routed back correctly.
- Tree stops returning results and requester 1 streams beats. Required: exactly 8 beats accepted, req_ready=0 on the 9th, and one vld_i=8'hFF pop allows exactly one more issue.
- Lanes return out of phase: lane 0 returns beats A,B early, lane 7 returns them late. Required: rsp_vld[tagA][0] precedes rsp_vld[tagB][0], and lane 7 routes A then B correctly.
- vld_i[3] pulses with nothing outstanding. Required: err=1 and stays set, no rsp_vld, queues unaffected.
- rst_n is asserted mid-stream with 5 beats outstanding. Required: all outputs at reset values immediately (asynchronous), busy=0, and the next grant goes to requester 0.

Source files
------------

// File: rtl/pmp_pkg.sv
// Shared geometry defaults, tag/beat types and the round-robin pick helper
// used by the match-tree arbiter.
package pmp_pkg;

  localparam int P_N_REQ           = 4;
  localparam int P_BEAT_SIZE       = 8;
  localparam int P_DATA_WIDTH      = 16;
  localparam int P_MAX_OUTSTANDING = 8;

  typedef logic [$clog2(P_N_REQ)-1:0] tag_t;
  typedef logic [P_BEAT_SIZE-1:0][P_DATA_WIDTH-1:0] beat_t;

  // Index of the first set bit of valid at or after ptr, wrapping modulo n.
  // Returns 0 when nothing is set; callers qualify with |valid.
  function automatic int rr_pick(input logic [31:0] valid, input int n, input int ptr);
    int   idx;
    logic found;
    rr_pick = 0;
    found   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        idx = (ptr + i) % n;
        if (!found && (((valid >> idx) & 32'd1) != 32'd0)) begin
          found   = 1'b1;
          rr_pick = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/match_arbiter_tag_fifo.sv
// Per-lane return-tag queue: power-of-two depth, wrap-bit pointers and a
// first-word-fall-through output so the head tag is usable in the pop cycle.
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign dout     = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/match_arbiter.sv
// Round-robin arbiter sharing one phase-match tree among N_REQ row controllers;
// per-lane tag queues route each returning disparity to the issuing controller.
module match_arbiter
  import pmp_pkg::*;
#(
  parameter int N_REQ           = P_N_REQ,
  parameter int BEAT_SIZE       = P_BEAT_SIZE,
  parameter int DATA_WIDTH      = P_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = P_MAX_OUTSTANDING
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_REQ-1:0]                      req_valid,
  output logic [N_REQ-1:0]                      req_ready,
  input  logic [N_REQ*BEAT_SIZE*DATA_WIDTH-1:0] req_phase,
  input  logic [N_REQ*BEAT_SIZE*DATA_WIDTH-1:0] req_pos,
  output logic [BEAT_SIZE*DATA_WIDTH-1:0]       abs_phase1,
  output logic [BEAT_SIZE*DATA_WIDTH-1:0]       abs_phase1_pos,
  output logic                                  vld_o,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0]       disparity,
  input  logic [BEAT_SIZE-1:0]                  vld_i,
  output logic [BEAT_SIZE*DATA_WIDTH-1:0]       rsp_disparity,
  output logic [N_REQ*BEAT_SIZE-1:0]            rsp_vld,
  output logic                                  busy,
  output logic                                  err
);

  localparam int TAG_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BEAT_W = BEAT_SIZE * DATA_WIDTH;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

  logic [TAG_W-1:0]           rr_ptr_q, rr_ptr_d, pick_idx;
  logic [N_REQ-1:0]           grant;
  logic                       stall, hs;
  logic [BEAT_SIZE-1:0]       lane_full, lane_empty, lane_pop;
  logic [TAG_W-1:0]           lane_tag   [BEAT_SIZE];
  logic [CNT_W-1:0]           lane_count [BEAT_SIZE];
  logic [BEAT_W-1:0]          abs_phase_q, abs_phase_d;
  logic [BEAT_W-1:0]          abs_pos_q, abs_pos_d;
  logic [BEAT_W-1:0]          rsp_disp_q, rsp_disp_d;
  logic                       vld_q;
  logic [N_REQ*BEAT_SIZE-1:0] rsp_vld_q, rsp_vld_d;
  logic                       err_q, err_d;

  always_comb begin
    pick_idx = TAG_W'(rr_pick(32'(req_valid), N_REQ, int'(rr_ptr_q)));
    grant    = '0;
    if (|req_valid) begin
      grant[pick_idx] = 1'b1;
    end
  end

  // Stall looks at current occupancy only, so a full lane blocks issue even
  // in a cycle where it is also being popped.
  assign stall     = |lane_full;
  assign req_ready = grant & {N_REQ{~stall}};
  assign hs        = |req_ready;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    abs_phase_d = abs_phase_q;
    abs_pos_d   = abs_pos_q;
    if (hs) begin
      rr_ptr_d = (pick_idx == TAG_W'(N_REQ - 1)) ? '0 : pick_idx + TAG_W'(1);
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (req_ready[k]) begin
        abs_phase_d = req_phase[k*BEAT_W +: BEAT_W];
        abs_pos_d   = req_pos[k*BEAT_W +: BEAT_W];
      end
    end
  end

  for (genvar gi = 0; gi < BEAT_SIZE; gi++) begin : g_lane
    tag_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (hs),
      .pop   (lane_pop[gi]),
      .din   (pick_idx),
      .dout  (lane_tag[gi]),
      .full  (lane_full[gi]),
      .empty (lane_empty[gi]),
      .count (lane_count[gi])
    );

    assign lane_pop[gi] = vld_i[gi] & ~lane_empty[gi];
    assign rsp_disp_d[gi*DATA_WIDTH +: DATA_WIDTH] = lane_pop[gi]
        ? disparity[gi*DATA_WIDTH +: DATA_WIDTH]
        : rsp_disp_q[gi*DATA_WIDTH +: DATA_WIDTH];

    for (genvar gk = 0; gk < N_REQ; gk++) begin : g_route
      assign rsp_vld_d[gk*BEAT_SIZE + gi] = lane_pop[gi] & (lane_tag[gi] == TAG_W'(gk));
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < BEAT_SIZE; i++) begin
      busy = busy | (lane_count[i] != '0);
    end
  end

  // A strobe on an empty lane means the tree and arbiter lost sync; latch it.
  assign err_d = err_q | (|(vld_i & lane_empty));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      abs_phase_q <= '0;
      abs_pos_q   <= '0;
      rsp_disp_q  <= '0;
      vld_q       <= 1'b0;
      rsp_vld_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      abs_phase_q <= abs_phase_d;
      abs_pos_q   <= abs_pos_d;
      rsp_disp_q  <= rsp_disp_d;
      vld_q       <= hs;
      rsp_vld_q   <= rsp_vld_d;
      err_q       <= err_d;
    end
  end

  assign abs_phase1     = abs_phase_q;
  assign abs_phase1_pos = abs_pos_q;
  assign vld_o          = vld_q;
  assign rsp_disparity  = rsp_disp_q;
  assign rsp_vld        = rsp_vld_q;
  assign err            = err_q;

endmodule
